// File: rtl/pcie_rx_bridge_param.sv
// AVST RX (multi-channel) to AXI4-Stream bridge with ready-latency skid FIFO.
// Optional protocol checker enabled by defining PCIE_RX_BRIDGE_PROTO_CHK_EN.

module pcie_rx_lane (
  input  logic        vld,
  input  logic        sop,
  input  logic        eop,
  input  logic [2:0]  pfn,
  input  logic [10:0] vfn,
  output logic        sop_q,
  output logic        eop_q,
  output logic [2:0]  pfn_q,
  output logic [10:0] vfn_q
);
  assign sop_q = vld & sop;
  assign eop_q = vld & eop;
  assign pfn_q = vld ? pfn : 3'd0;
  assign vfn_q = vld ? vfn : 11'd0;
endmodule

module pcie_rx_bridge_param #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 256,
  parameter int HDR_W         = 128,
  parameter int READY_LATENCY = 3,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                                avl_clk,
  input  logic                                avl_rst_n,
  input  logic [NUM_CH-1:0]                   avl_rx_valid,
  input  logic [NUM_CH-1:0]                   avl_rx_sop,
  input  logic [NUM_CH-1:0]                   avl_rx_eop,
  input  logic [NUM_CH-1:0]                   avl_rx_mmio_req,
  input  logic [NUM_CH-1:0]                   avl_rx_vf_active,
  input  logic [NUM_CH*HDR_W-1:0]             avl_rx_hdr,
  input  logic [NUM_CH*DATA_W-1:0]            avl_rx_data,
  input  logic [NUM_CH*3-1:0]                 avl_rx_bar,
  input  logic [NUM_CH*3-1:0]                 avl_rx_pfn,
  input  logic [NUM_CH*11-1:0]                avl_rx_vfn,
  output logic                                avl_rx_ready,
  output logic                                axis_rx_tvalid,
  input  logic                                axis_rx_tready,
  output logic                                axis_rx_tlast,
  output logic [NUM_CH*(3+HDR_W+DATA_W)-1:0]  axis_rx_tdata,
  output logic [NUM_CH*19-1:0]                axis_rx_tuser,
  output logic                                rx_overflow_err,
  output logic                                rx_proto_err
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH+1);
  localparam int TW     = 3 + HDR_W + DATA_W;
  localparam int RDY_TH = FIFO_DEPTH - READY_LATENCY - 2;

  typedef struct packed {
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] sop;
    logic [NUM_CH-1:0] eop;
  } flag_t;

  typedef struct packed {
    logic [NUM_CH-1:0]             mmio;
    logic [NUM_CH-1:0]             vfa;
    logic [NUM_CH-1:0][2:0]        bar;
    logic [NUM_CH-1:0][2:0]        pfn;
    logic [NUM_CH-1:0][10:0]       vfn;
    logic [NUM_CH-1:0][HDR_W-1:0]  hdr;
    logic [NUM_CH-1:0][DATA_W-1:0] data;
  } body_t;

  logic [NUM_CH-1:0]    sop_c, eop_c;
  logic [NUM_CH*3-1:0]  pfn_c;
  logic [NUM_CH*11-1:0] vfn_c;
  flag_t cur_flag, in_flag, out_flag;
  body_t cur_body, in_body, out_body;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    pcie_rx_lane u_lane (
      .vld   (avl_rx_valid[c]),
      .sop   (avl_rx_sop[c]),
      .eop   (avl_rx_eop[c]),
      .pfn   (avl_rx_pfn[c*3 +: 3]),
      .vfn   (avl_rx_vfn[c*11 +: 11]),
      .sop_q (sop_c[c]),
      .eop_q (eop_c[c]),
      .pfn_q (pfn_c[c*3 +: 3]),
      .vfn_q (vfn_c[c*11 +: 11])
    );
  end

  assign cur_flag = '{vld: avl_rx_valid, sop: sop_c, eop: eop_c};
  assign cur_body = '{mmio: avl_rx_mmio_req, vfa: avl_rx_vf_active, bar: avl_rx_bar,
                      pfn: pfn_c, vfn: vfn_c, hdr: avl_rx_hdr, data: avl_rx_data};

  // Input register captures regardless of ready: the source may still be in its latency window.
  logic in_vld;
  always_ff @(posedge avl_clk or negedge avl_rst_n) begin
    if (!avl_rst_n) begin
      in_vld  <= 1'b0;
      in_flag <= '0;
    end else begin
      in_vld <= |avl_rx_valid;
      if (|avl_rx_valid) in_flag <= cur_flag;
    end
  end

  always_ff @(posedge avl_clk) begin
    if (|avl_rx_valid) in_body <= cur_body;
  end

  flag_t mem_flag [FIFO_DEPTH];
  body_t mem_body [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          out_vld;
  logic          pop, full, push, mem_empty, bypass, mem_wr, load_mem;

  // Output register is the head of the queue; it is filled directly when the memory is empty.
  assign pop       = out_vld & axis_rx_tready;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push      = in_vld & (~full | pop);
  assign mem_empty = (wr_ptr == rd_ptr);
  assign load_mem  = ~mem_empty & (~out_vld | pop);
  assign bypass    = push & mem_empty & (~out_vld | pop);
  assign mem_wr    = push & ~bypass;

  always_ff @(posedge avl_clk) begin
    if (mem_wr) begin
      mem_flag[wr_ptr[AW-1:0]] <= in_flag;
      mem_body[wr_ptr[AW-1:0]] <= in_body;
    end
    if (load_mem)    out_body <= mem_body[rd_ptr[AW-1:0]];
    else if (bypass) out_body <= in_body;
  end

  always_ff @(posedge avl_clk or negedge avl_rst_n) begin
    if (!avl_rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      out_vld         <= 1'b0;
      out_flag        <= '0;
      avl_rx_ready    <= 1'b0;
      rx_overflow_err <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (load_mem) begin
        rd_ptr   <= rd_ptr + (AW+1)'(1);
        out_flag <= mem_flag[rd_ptr[AW-1:0]];
        out_vld  <= 1'b1;
      end else if (bypass) begin
        out_flag <= in_flag;
        out_vld  <= 1'b1;
      end else if (pop) begin
        out_flag <= '0;
        out_vld  <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      avl_rx_ready <= (count < CW'(RDY_TH));
      if (in_vld && full && !pop) rx_overflow_err <= 1'b1;
    end
  end

  assign axis_rx_tvalid = out_vld;
  assign axis_rx_tlast  = 1'b1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign axis_rx_tdata[c*TW +: TW] = {out_flag.vld[c], out_flag.sop[c], out_flag.eop[c],
                                        out_body.hdr[c], out_body.data[c]};
    assign axis_rx_tuser[c*19 +: 19] = {out_body.mmio[c], out_body.vfa[c], out_body.pfn[c],
                                        out_body.vfn[c], out_body.bar[c]};
  end

`ifdef PCIE_RX_BRIDGE_PROTO_CHK_EN
  logic in_pkt, pkt_nxt, perr, proto_q;

  // Walk channels low to high so a packet may open and close within one beat.
  always_comb begin
    pkt_nxt = in_pkt;
    perr    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_flag.vld[c]) begin
        if (in_flag.sop[c]) begin
          if (pkt_nxt) perr = 1'b1;
          pkt_nxt = 1'b1;
        end else if (!pkt_nxt) begin
          perr = 1'b1;
        end
        if (in_flag.eop[c]) pkt_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge avl_clk or negedge avl_rst_n) begin
    if (!avl_rst_n) begin
      in_pkt  <= 1'b0;
      proto_q <= 1'b0;
    end else if (in_vld) begin
      in_pkt <= pkt_nxt;
      if (perr) proto_q <= 1'b1;
    end
  end

  assign rx_proto_err = proto_q;
`else
  assign rx_proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_rx_bridge_param.sv
// Directed scoreboard bench for pcie_rx_bridge_param at default parameters.
module tb_pcie_rx_bridge_param;
  localparam int NC  = 2;
  localparam int DW  = 256;
  localparam int HW  = 128;
  localparam int TW  = 3 + HW + DW;
  localparam int TDW = NC * TW;
  localparam int TUW = NC * 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0]    valid, sop, eop, mmio, vfa;
  logic [NC*HW-1:0] hdr;
  logic [NC*DW-1:0] data;
  logic [NC*3-1:0]  bar, pfn;
  logic [NC*11-1:0] vfn;
  logic             ready, tvalid, tready, tlast, ovf, perr;
  logic [TDW-1:0]   tdata;
  logic [TUW-1:0]   tuser;

  int n_cmp = 0;
  int n_err = 0;
  logic [TDW-1:0] q_d [$];
  logic [TUW-1:0] q_u [$];

  always #5 clk = ~clk;

  pcie_rx_bridge_param dut (
    .avl_clk          (clk),
    .avl_rst_n        (rst_n),
    .avl_rx_valid     (valid),
    .avl_rx_sop       (sop),
    .avl_rx_eop       (eop),
    .avl_rx_mmio_req  (mmio),
    .avl_rx_vf_active (vfa),
    .avl_rx_hdr       (hdr),
    .avl_rx_data      (data),
    .avl_rx_bar       (bar),
    .avl_rx_pfn       (pfn),
    .avl_rx_vfn       (vfn),
    .avl_rx_ready     (ready),
    .axis_rx_tvalid   (tvalid),
    .axis_rx_tready   (tready),
    .axis_rx_tlast    (tlast),
    .axis_rx_tdata    (tdata),
    .axis_rx_tuser    (tuser),
    .rx_overflow_err  (ovf),
    .rx_proto_err     (perr)
  );

  task automatic chk(input string tag, input logic [TDW-1:0] got, input logic [TDW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = '0;
    sop   = '0;
    eop   = '0;
  endtask

  // Drive one beat with random payload; push the expected AXI view when it should be stored.
  task automatic send(input logic [NC-1:0] v, input logic [NC-1:0] s, input logic [NC-1:0] e,
                      input bit a5, input bit exp_push);
    logic [TDW-1:0] ed;
    logic [TUW-1:0] eu;
    valid = v;
    sop   = s;
    eop   = e;
    mmio  = NC'($urandom);
    vfa   = NC'($urandom);
    bar   = (NC*3)'($urandom);
    pfn   = (NC*3)'($urandom);
    vfn   = (NC*11)'($urandom);
    for (int k = 0; k < NC*HW/32; k++) hdr[k*32 +: 32] = $urandom;
    for (int k = 0; k < NC*DW/32; k++) data[k*32 +: 32] = $urandom;
    if (a5) hdr[HW-1:0] = HW'(8'hA5);
    for (int c = 0; c < NC; c++) begin
      ed[c*TW +: TW] = {v[c], s[c] & v[c], e[c] & v[c], hdr[c*HW +: HW], data[c*DW +: DW]};
      eu[c*19 +: 19] = {mmio[c], vfa[c], v[c] ? pfn[c*3 +: 3] : 3'd0,
                        v[c] ? vfn[c*11 +: 11] : 11'd0, bar[c*3 +: 3]};
    end
    if (exp_push && |v) begin
      q_d.push_back(ed);
      q_u.push_back(eu);
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    for (int k = 0; k < bound && q_d.size() > 0; k++) tick();
    tick();
    tick();
    chk(tag, TDW'(q_d.size()), TDW'(0));
  endtask

  always @(negedge clk) begin
    if (tvalid === 1'b1 && tready === 1'b1) begin
      chk("beat_expected", TDW'(q_d.size() != 0), TDW'(1));
      if (q_d.size() != 0) begin
        chk("tdata", tdata, q_d.pop_front());
        chk("tuser", TDW'(tuser), TDW'(q_u.pop_front()));
        chk("tlast", TDW'(tlast), TDW'(1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    logic [NC-1:0] m;
    tready = 1'b0;
    idle();
    mmio = '0; vfa = '0; hdr = '0; data = '0; bar = '0; pfn = '0; vfn = '0;

    // Reset state
    #12;
    chk("rst_tvalid", TDW'(tvalid), TDW'(0));
    chk("rst_ready",  TDW'(ready),  TDW'(0));
    chk("rst_ovf",    TDW'(ovf),    TDW'(0));
    chk("rst_perr",   TDW'(perr),   TDW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", TDW'(ready), TDW'(1));
    chk("tvalid_after_reset", TDW'(tvalid), TDW'(0));
    tick();
    tick();

    // Single beat, two-cycle latency, one-cycle tvalid pulse
    tready = 1'b1;
    send(2'b01, 2'b11, 2'b11, 1'b1, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("lat_cyc1_tvalid", TDW'(tvalid), TDW'(0));
    tick();
    @(negedge clk);
    chk("lat_cyc2_tvalid", TDW'(tvalid), TDW'(1));
    chk("lat_cyc2_hdr", TDW'(tdata[DW +: HW]), TDW'(8'hA5));
    tick();
    @(negedge clk);
    chk("pulse_end_tvalid", TDW'(tvalid), TDW'(0));

    // Fill with tready low: ready drops at count 11, late beats stored, 17th dropped
    tready = 1'b0;
    tick();
    tick();
    for (int i = 1; i <= 17; i++) begin
      chk($sformatf("ready_fill_%0d", i), TDW'(ready), TDW'(i < 14));
      send(2'b11, 2'b11, 2'b11, 1'b0, i <= 16);
      tick();
    end
    idle();
    chk("ovf_when_full", TDW'(ovf), TDW'(0));
    tick();
    chk("ovf_after_drop", TDW'(ovf), TDW'(1));
    chk("ready_when_full", TDW'(ready), TDW'(0));
    tready = 1'b1;
    wait_drain("drain_fill", 100);
    chk("ovf_sticky", TDW'(ovf), TDW'(1));
    chk("ready_after_drain", TDW'(ready), TDW'(1));

    // Reset mid-packet with beats queued
    tready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      send(2'b11, (j == 0) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b1);
      tick();
    end
    idle();
    tick();
    tick();
    chk("tvalid_before_reset", TDW'(tvalid), TDW'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", TDW'(tvalid), TDW'(0));
    chk("mid_rst_ready", TDW'(ready), TDW'(0));
    chk("mid_rst_ovf", TDW'(ovf), TDW'(0));
    chk("mid_rst_tdata_vld", TDW'({tdata[2*TW-1], tdata[TW-1]}), TDW'(0));
    q_d.delete();
    q_u.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_mid_rst", TDW'(ready), TDW'(1));
    tick();
    tick();
    tick();
    chk("empty_after_mid_rst", TDW'(tvalid), TDW'(0));

    // 40-beat stream with tready toggling 1010
    sent = 0;
    for (int cyc = 0; cyc < 600 && sent < 40; cyc++) begin
      tready = (cyc % 2 == 0);
      if (ready) begin
        case (sent % 3)
          0:       m = 2'b01;
          1:       m = 2'b11;
          default: m = 2'b10;
        endcase
        send(m, 2'b11, 2'b11, 1'b0, 1'b1);
        sent++;
      end else begin
        idle();
      end
      tick();
    end
    idle();
    chk("stream_sent", TDW'(sent), TDW'(40));
    tready = 1'b1;
    wait_drain("drain_stream", 200);
    chk("stream_ovf", TDW'(ovf), TDW'(0));

    // Protocol violation: ch0 sop then ch1 sop with no eop
    chk("proto_before", TDW'(perr), TDW'(0));
    send(2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    tick();
`ifdef PCIE_RX_BRIDGE_PROTO_CHK_EN
    chk("proto_err", TDW'(perr), TDW'(1));
`else
    chk("proto_err", TDW'(perr), TDW'(0));
`endif
    wait_drain("drain_proto", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
